// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache CPU port between an instruction-fetch
// port (0) and a data port (1), with a watchdog that aborts stalled transactions.
module cache_port_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 20,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0,
  input  logic              rw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,

  input  logic              req1,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,

  output logic              cache_req,
  output logic              cache_rw,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  input  logic              cache_done,
  input  logic [DATA_W-1:0] cache_rdata,

  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q;
  logic                last_grant_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                cache_req_q;
  logic                cache_rw_q;
  logic [ADDR_W-1:0]   cache_addr_q;
  logic [DATA_W-1:0]   cache_wdata_q;
  logic                done0_q, done1_q;
  logic                err0_q, err1_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic                busy_q;
  logic                grant_d;

  // On contention the port that was not served last wins.
  always_comb begin
    grant_d = req1;
    if (req0 && req1) begin
      grant_d = ~last_grant_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      cache_req_q   <= 1'b0;
      cache_rw_q    <= 1'b0;
      cache_addr_q  <= '0;
      cache_wdata_q <= '0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            cache_req_q   <= 1'b1;
            busy_q        <= 1'b1;
            cache_rw_q    <= grant_d ? rw1 : rw0;
            cache_addr_q  <= grant_d ? addr1 : addr0;
            cache_wdata_q <= grant_d ? wdata1 : wdata0;
            last_grant_q  <= grant_d;
            cnt_q         <= '0;
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          // A completion arriving on the watchdog's last cycle still counts as success.
          if (cache_done) begin
            cache_req_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= RESP;
            if (last_grant_q) begin
              done1_q  <= 1'b1;
              err1_q   <= 1'b0;
              rdata1_q <= cache_rdata;
            end else begin
              done0_q  <= 1'b1;
              err0_q   <= 1'b0;
              rdata0_q <= cache_rdata;
            end
          end else if (WD_EN && (cnt_q == TO_LAST)) begin
            cache_req_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= RESP;
            if (last_grant_q) begin
              done1_q  <= 1'b1;
              err1_q   <= 1'b1;
              rdata1_q <= '0;
            end else begin
              done0_q  <= 1'b1;
              err0_q   <= 1'b1;
              rdata0_q <= '0;
            end
          end
        end
        RESP: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cache_req   = cache_req_q;
  assign cache_rw    = cache_rw_q;
  assign cache_addr  = cache_addr_q;
  assign cache_wdata = cache_wdata_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign err0        = err0_q;
  assign err1        = err1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed and randomized checks of cache_port_arbiter against a
// transaction-level model of arbitration, completion and watchdog rules.
module tb_cache_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 20;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, rw0, req1, rw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          done0, err0, done1, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          cache_req, cache_rw, cache_done, busy;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_wdata, cache_rdata;

  cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .err1(err1), .rdata1(rdata1),
    .cache_req(cache_req), .cache_rw(cache_rw), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_done(cache_done), .cache_rdata(cache_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: who was served last, what each port should currently read back,
  // and the payload each requester is presenting.
  int            last_served;
  logic [DW-1:0] rdata_exp [2];
  logic          pay_rw    [2];
  logic [AW-1:0] pay_addr  [2];
  logic [DW-1:0] pay_wdata [2];
  int            grants [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic raise_with(input int p, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    pay_rw[p] = rw; pay_addr[p] = a; pay_wdata[p] = wd;
    if (p == 0) begin req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = wd; end
    else        begin req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = wd; end
  endtask

  task automatic raise(input int p);
    raise_with(p, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
  endtask

  task automatic drop(input int p);
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_done0"}, done0, 0);
    chk({tag, "_done1"}, done1, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_creq"}, cache_req, 0);
    chk({tag, "_rdata0"}, rdata0, rdata_exp[0]);
    chk({tag, "_rdata1"}, rdata1, rdata_exp[1]);
  endtask

  // One whole transaction from IDLE: grant, wait d cycles for cache_done
  // (0 = never), response pulse, back to IDLE. The winner drops req in RESP.
  task automatic txn(input int d, input bit use_fix, input logic [DW-1:0] fix_rd);
    int w;
    bit finished;
    logic [DW-1:0] rd;
    logic exp_err;
    if (req0 && req1) w = 1 - last_served;
    else              w = req1 ? 1 : 0;
    step();
    chk("grant_creq", cache_req, 1);
    chk("grant_busy", busy, 1);
    chk("grant_addr", cache_addr, pay_addr[w]);
    chk("grant_rw", cache_rw, pay_rw[w]);
    chk("grant_wdata", cache_wdata, pay_wdata[w]);
    chk("grant_nodone", done0 | done1, 0);
    last_served = w;
    grants.push_back(w);
    finished = 0;
    exp_err = 0;
    for (int k = 1; k <= TO && !finished; k++) begin
      rd = use_fix ? fix_rd : DW'($urandom);
      cache_done = (k == d);
      cache_rdata = rd;
      step();
      cache_done = 1'b0;
      if (k == d) begin
        rdata_exp[w] = rd; exp_err = 0; finished = 1;
      end else if (k == TO) begin
        rdata_exp[w] = '0; exp_err = 1; finished = 1;
      end
      if (finished) begin
        chk("resp_done_w", (w == 1) ? done1 : done0, 1);
        chk("resp_done_other", (w == 1) ? done0 : done1, 0);
        chk("resp_err", (w == 1) ? err1 : err0, exp_err);
        chk("resp_rdata0", rdata0, rdata_exp[0]);
        chk("resp_rdata1", rdata1, rdata_exp[1]);
        chk("resp_creq", cache_req, 0);
        chk("resp_busy", busy, 0);
      end else begin
        chk("wait_creq", cache_req, 1);
        chk("wait_busy", busy, 1);
        chk("wait_nodone", done0 | done1, 0);
        chk("wait_addr", cache_addr, pay_addr[w]);
      end
    end
    drop(w);
    step();
    chk_quiet("idle");
    chk("idle_err", err0 | err1, 0);
  endtask

  task automatic spurious();
    cache_done = 1'b1;
    cache_rdata = 20'hFFFFF;
    step();
    cache_done = 1'b0;
    chk_quiet("spur");
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; rw0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; rw1 = 0; addr1 = '0; wdata1 = '0;
    cache_done = 0; cache_rdata = '0;
    last_served = 1;
    rdata_exp[0] = '0; rdata_exp[1] = '0;
    step();
    step();
    chk_quiet("reset");
    chk("reset_err", err0 | err1, 0);
    rst = 1'b0;

    // Single read.
    raise_with(0, 1'b0, 10'h155, DW'($urandom));
    txn(3, 1, 20'hABCDE);

    // Simultaneous request after reset (port 1 write), then fairness.
    rst = 1'b1; step(); rst = 1'b0;
    last_served = 1; rdata_exp[0] = '0; rdata_exp[1] = '0;
    grants.delete();
    raise_with(0, 1'b0, 10'h0AA, 20'h0);
    raise_with(1, 1'b1, 10'h3FF, 20'h12345);
    txn(2, 0, '0);
    txn(4, 0, '0);
    for (int i = 0; i < 6; i++) begin
      if (!req0) raise(0);
      if (!req1) raise(1);
      txn(1 + (i % 3), 0, '0);
    end
    drop(0); drop(1);
    for (int i = 0; i < grants.size(); i++) chk("fair_order", grants[i], i % 2);

    // Watchdog abort, then completion on the last watchdog cycle.
    raise(1);
    txn(0, 0, '0);
    raise(0);
    txn(TO, 0, '0);

    spurious();

    // Asynchronous reset while BUSY.
    raise(1);
    step();
    chk("pre_rst_creq", cache_req, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_creq", cache_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done0 | done1, 0);
    chk("arst_err", err0 | err1, 0);
    chk("arst_rdata0", rdata0, 0);
    chk("arst_rdata1", rdata1, 0);
    drop(1);
    last_served = 1; rdata_exp[0] = '0; rdata_exp[1] = '0;
    step();
    rst = 1'b0;
    grants.delete();
    raise(0); raise(1);
    txn(2, 0, '0);
    chk("post_rst_first", grants[0], 0);
    txn(1, 0, '0);

    // Randomized mix of single/contended requests and latencies.
    for (int i = 0; i < 40; i++) begin
      if (!req0 && !req1 && $urandom_range(0, 3) == 0) spurious();
      if (!req0 && $urandom_range(0, 1) == 1) raise(0);
      if (!req1 && $urandom_range(0, 1) == 1) raise(1);
      if (!req0 && !req1) raise(int'($urandom_range(0, 1)));
      txn(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO + 2)), 0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
